// File: rtl/tlb_core.sv
// tlb_core: MIPS32-style paired-entry TLB array.
//
// Holds TLBNUM entries: VPN2, ASID, G, and per-page PFN/C/D/V for the even and
// odd pages. Provides:
//   - s0_* : combinational search port (lowest matching index wins)
//   - w_*  : synchronous write port used by TLBWI/TLBWR (we qualifies)
//   - r_*  : combinational read port used by TLBR
//   - random_index : CP0 Random value, counts down from TLBNUM-1 to wired
//
// Clock/reset: clk, synchronous active-high rst. Reset clears every entry and
// loads random_index with TLBNUM-1. Reset wins over a concurrent write.
//
// Optional macro TLB_DUAL_SEARCH_EN adds a second, independent search port
// s1_* for the data-side MMU. Without it, only s0_* exists.
module tlb_core #(
  parameter int unsigned TLBNUM = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  // search port 0
  input  logic [18:0]               s0_vpn,
  input  logic                      s0_odd,
  input  logic [7:0]                s0_asid,
  output logic                      s0_found,
  output logic [$clog2(TLBNUM)-1:0] s0_index,
  output logic [19:0]               s0_pfn,
  output logic [2:0]                s0_c,
  output logic                      s0_d,
  output logic                      s0_v,
`ifdef TLB_DUAL_SEARCH_EN
  // search port 1
  input  logic [18:0]               s1_vpn,
  input  logic                      s1_odd,
  input  logic [7:0]                s1_asid,
  output logic                      s1_found,
  output logic [$clog2(TLBNUM)-1:0] s1_index,
  output logic [19:0]               s1_pfn,
  output logic [2:0]                s1_c,
  output logic                      s1_d,
  output logic                      s1_v,
`endif
  // write port
  input  logic                      we,
  input  logic [$clog2(TLBNUM)-1:0] w_index,
  input  logic [18:0]               w_vpn2,
  input  logic [7:0]                w_asid,
  input  logic                      w_g,
  input  logic [19:0]               w_pfn0,
  input  logic [2:0]                w_c0,
  input  logic                      w_d0,
  input  logic                      w_v0,
  input  logic [19:0]               w_pfn1,
  input  logic [2:0]                w_c1,
  input  logic                      w_d1,
  input  logic                      w_v1,
  // read port
  input  logic [$clog2(TLBNUM)-1:0] r_index,
  output logic [18:0]               r_vpn2,
  output logic [7:0]                r_asid,
  output logic                      r_g,
  output logic [19:0]               r_pfn0,
  output logic [2:0]                r_c0,
  output logic                      r_d0,
  output logic                      r_v0,
  output logic [19:0]               r_pfn1,
  output logic [2:0]                r_c1,
  output logic                      r_d1,
  output logic                      r_v1,
  // random index
  input  logic [$clog2(TLBNUM)-1:0] wired,
  output logic [$clog2(TLBNUM)-1:0] random_index
);

  localparam int unsigned IdxW = $clog2(TLBNUM);
  localparam logic [IdxW-1:0] RndTop = IdxW'(TLBNUM - 1);

  typedef struct packed {
    logic            found;
    logic [IdxW-1:0] index;
    logic [19:0]     pfn;
    logic [2:0]      c;
    logic            d;
    logic            v;
  } srch_t;

  // Entry storage
  logic [18:0] vpn2_q [TLBNUM];
  logic [7:0]  asid_q [TLBNUM];
  logic        g_q    [TLBNUM];
  logic [19:0] pfn0_q [TLBNUM];
  logic [2:0]  c0_q   [TLBNUM];
  logic        d0_q   [TLBNUM];
  logic        v0_q   [TLBNUM];
  logic [19:0] pfn1_q [TLBNUM];
  logic [2:0]  c1_q   [TLBNUM];
  logic        d1_q   [TLBNUM];
  logic        v1_q   [TLBNUM];

  logic [IdxW-1:0] rnd_q, rnd_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TLBNUM; i++) begin
        vpn2_q[i] <= '0;
        asid_q[i] <= '0;
        g_q[i]    <= 1'b0;
        pfn0_q[i] <= '0;
        c0_q[i]   <= '0;
        d0_q[i]   <= 1'b0;
        v0_q[i]   <= 1'b0;
        pfn1_q[i] <= '0;
        c1_q[i]   <= '0;
        d1_q[i]   <= 1'b0;
        v1_q[i]   <= 1'b0;
      end
    end else if (we) begin
      vpn2_q[w_index] <= w_vpn2;
      asid_q[w_index] <= w_asid;
      g_q[w_index]    <= w_g;
      pfn0_q[w_index] <= w_pfn0;
      c0_q[w_index]   <= w_c0;
      d0_q[w_index]   <= w_d0;
      v0_q[w_index]   <= w_v0;
      pfn1_q[w_index] <= w_pfn1;
      c1_q[w_index]   <= w_c1;
      d1_q[w_index]   <= w_d1;
      v1_q[w_index]   <= w_v1;
    end
  end

  // Search reads only the registered entries, so a same-cycle write is not
  // bypassed. Scanning from the top down lets the lowest match win.
  function automatic srch_t search(input logic [18:0] vpn, input logic odd,
                                   input logic [7:0] asid);
    srch_t r;
    r = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (vpn2_q[i] == vpn && (g_q[i] || asid_q[i] == asid)) begin
        r.found = 1'b1;
        r.index = IdxW'(i);
        r.pfn   = odd ? pfn1_q[i] : pfn0_q[i];
        r.c     = odd ? c1_q[i]   : c0_q[i];
        r.d     = odd ? d1_q[i]   : d0_q[i];
        r.v     = odd ? v1_q[i]   : v0_q[i];
      end
    end
    return r;
  endfunction

  srch_t s0_res;

  always_comb begin
    s0_res = search(s0_vpn, s0_odd, s0_asid);
  end

  assign s0_found = s0_res.found;
  assign s0_index = s0_res.index;
  assign s0_pfn   = s0_res.pfn;
  assign s0_c     = s0_res.c;
  assign s0_d     = s0_res.d;
  assign s0_v     = s0_res.v;

`ifdef TLB_DUAL_SEARCH_EN
  srch_t s1_res;

  always_comb begin
    s1_res = search(s1_vpn, s1_odd, s1_asid);
  end

  assign s1_found = s1_res.found;
  assign s1_index = s1_res.index;
  assign s1_pfn   = s1_res.pfn;
  assign s1_c     = s1_res.c;
  assign s1_d     = s1_res.d;
  assign s1_v     = s1_res.v;
`endif

  // Read port
  assign r_vpn2 = vpn2_q[r_index];
  assign r_asid = asid_q[r_index];
  assign r_g    = g_q[r_index];
  assign r_pfn0 = pfn0_q[r_index];
  assign r_c0   = c0_q[r_index];
  assign r_d0   = d0_q[r_index];
  assign r_v0   = v0_q[r_index];
  assign r_pfn1 = pfn1_q[r_index];
  assign r_c1   = c1_q[r_index];
  assign r_d1   = d1_q[r_index];
  assign r_v1   = v1_q[r_index];

  // Random counts down to wired then wraps to the top. The ==0 term catches a
  // counter left below a freshly raised wired value.
  always_comb begin
    rnd_d = rnd_q - 1'b1;
    if (rnd_q == wired || rnd_q == '0) begin
      rnd_d = RndTop;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rnd_q <= RndTop;
    end else begin
      rnd_q <= rnd_d;
    end
  end

  assign random_index = rnd_q;

endmodule

// File: tb/tb_tlb_core.sv
module tb_tlb_core;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [18:0] s0_vpn;
  logic        s0_odd;
  logic [7:0]  s0_asid;
  logic        s0_found;
  logic [3:0]  s0_index;
  logic [19:0] s0_pfn;
  logic [2:0]  s0_c;
  logic        s0_d;
  logic        s0_v;
`ifdef TLB_DUAL_SEARCH_EN
  logic [18:0] s1_vpn;
  logic        s1_odd;
  logic [7:0]  s1_asid;
  logic        s1_found;
  logic [3:0]  s1_index;
  logic [19:0] s1_pfn;
  logic [2:0]  s1_c;
  logic        s1_d;
  logic        s1_v;
`endif
  logic        we;
  logic [3:0]  w_index;
  logic [18:0] w_vpn2;
  logic [7:0]  w_asid;
  logic        w_g;
  logic [19:0] w_pfn0, w_pfn1;
  logic [2:0]  w_c0, w_c1;
  logic        w_d0, w_v0, w_d1, w_v1;
  logic [3:0]  r_index;
  logic [18:0] r_vpn2;
  logic [7:0]  r_asid;
  logic        r_g;
  logic [19:0] r_pfn0, r_pfn1;
  logic [2:0]  r_c0, r_c1;
  logic        r_d0, r_v0, r_d1, r_v1;
  logic [3:0]  wired;
  logic [3:0]  random_index;

  tlb_core #(.TLBNUM(N)) dut (
    .clk(clk), .rst(rst),
    .s0_vpn(s0_vpn), .s0_odd(s0_odd), .s0_asid(s0_asid), .s0_found(s0_found),
    .s0_index(s0_index), .s0_pfn(s0_pfn), .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
`ifdef TLB_DUAL_SEARCH_EN
    .s1_vpn(s1_vpn), .s1_odd(s1_odd), .s1_asid(s1_asid), .s1_found(s1_found),
    .s1_index(s1_index), .s1_pfn(s1_pfn), .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
`endif
    .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
    .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
    .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
    .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
    .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
    .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1),
    .wired(wired), .random_index(random_index)
  );

  always #5 clk = ~clk;

  // Reference model: a table of entries plus the Random value.
  typedef struct {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0, pfn1;
    logic [2:0]  c0, c1;
    logic        d0, v0, d1, v1;
  } ent_t;

  ent_t m[N];
  int   m_rnd;
  int   checks = 0;
  int   errors = 0;

  // Expected search result {found, index, pfn, c, d, v}: first match in
  // ascending index order, zeros on a miss.
  function automatic logic [29:0] model_search(input logic [18:0] vpn, input logic odd,
                                               input logic [7:0] asid);
    for (int i = 0; i < N; i++) begin
      if (m[i].vpn2 == vpn && (m[i].g || m[i].asid == asid)) begin
        if (odd) return {1'b1, 4'(i), m[i].pfn1, m[i].c1, m[i].d1, m[i].v1};
        else     return {1'b1, 4'(i), m[i].pfn0, m[i].c0, m[i].d0, m[i].v0};
      end
    end
    return '0;
  endfunction

  function automatic logic [77:0] model_read(input int i);
    return {m[i].vpn2, m[i].asid, m[i].g, m[i].pfn0, m[i].c0, m[i].d0, m[i].v0,
            m[i].pfn1, m[i].c1, m[i].d1, m[i].v1};
  endfunction

  function automatic logic [29:0] got_s0();
    return {s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v};
  endfunction

  function automatic logic [77:0] got_r();
    return {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1};
  endfunction

  // Advance one clock and apply the same edge to the model.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < N; i++) m[i] = '{default: '0};
      m_rnd = N - 1;
    end else begin
      if (we) begin
        m[w_index] = '{vpn2: w_vpn2, asid: w_asid, g: w_g, pfn0: w_pfn0, c0: w_c0,
                       d0: w_d0, v0: w_v0, pfn1: w_pfn1, c1: w_c1, d1: w_d1, v1: w_v1};
      end
      if (m_rnd == int'(wired) || m_rnd == 0) m_rnd = N - 1;
      else m_rnd = m_rnd - 1;
    end
    #1;
  endtask

  task automatic set_write(input logic [3:0] idx, input logic [18:0] vpn2,
                           input logic [7:0] asid, input logic g,
                           input logic [19:0] pfn0, input logic [2:0] c0, input logic d0,
                           input logic v0, input logic [19:0] pfn1, input logic [2:0] c1,
                           input logic d1, input logic v1);
    w_index = idx; w_vpn2 = vpn2; w_asid = asid; w_g = g;
    w_pfn0 = pfn0; w_c0 = c0; w_d0 = d0; w_v0 = v0;
    w_pfn1 = pfn1; w_c1 = c1; w_d1 = d1; w_v1 = v1;
    we = 1'b1;
  endtask

  task automatic do_write(input logic [3:0] idx, input logic [18:0] vpn2,
                          input logic [7:0] asid, input logic g,
                          input logic [19:0] pfn0, input logic [2:0] c0, input logic d0,
                          input logic v0, input logic [19:0] pfn1, input logic [2:0] c1,
                          input logic d1, input logic v1);
    set_write(idx, vpn2, asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1);
    tick();
    we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b0; wired = 4'd0; r_index = 4'd3;
    s0_vpn = 19'h00400; s0_odd = 1'b0; s0_asid = 8'h00;
    w_index = '0; w_vpn2 = '0; w_asid = '0; w_g = 1'b0;
    w_pfn0 = '0; w_c0 = '0; w_d0 = 1'b0; w_v0 = 1'b0;
    w_pfn1 = '0; w_c1 = '0; w_d1 = 1'b0; w_v1 = 1'b0;
`ifdef TLB_DUAL_SEARCH_EN
    s1_vpn = 19'h00400; s1_odd = 1'b0; s1_asid = 8'h00;
`endif
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++;
    if (got_s0() !== 30'd0) begin
      errors++; $display("FAIL reset_search got %h want 0", got_s0());
    end
    checks++;
    if (random_index !== 4'd15) begin
      errors++; $display("FAIL reset_random got %0d want 15", random_index);
    end
    checks++;
    if (got_r() !== 78'd0) begin
      errors++; $display("FAIL reset_read got %h want 0", got_r());
    end
  endtask

  task automatic test_basic_search();
    do_write(4'd3, 19'h00400, 8'h05, 1'b0, 20'h12345, 3'd3, 1'b0, 1'b1,
             20'h6789A, 3'd0, 1'b0, 1'b0);
    s0_vpn = 19'h00400; s0_asid = 8'h05; s0_odd = 1'b0; #1;
    checks++;
    if (got_s0() !== {1'b1, 4'd3, 20'h12345, 3'd3, 1'b0, 1'b1}) begin
      errors++; $display("FAIL even_page got %h", got_s0());
    end
    s0_odd = 1'b1; #1;
    checks++;
    if (got_s0() !== {1'b1, 4'd3, 20'h6789A, 3'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL odd_page got %h", got_s0());
    end
    s0_asid = 8'h06; #1;
    checks++;
    if (got_s0() !== 30'd0) begin
      errors++; $display("FAIL asid_miss got %h want 0", got_s0());
    end
    r_index = 4'd3; #1;
    checks++;
    if (got_r() !== model_read(3)) begin
      errors++; $display("FAIL read_idx3 got %h want %h", got_r(), model_read(3));
    end
  endtask

  task automatic test_global_and_collision();
    do_write(4'd3, 19'h00400, 8'h05, 1'b1, 20'h12345, 3'd3, 1'b0, 1'b1,
             20'h6789A, 3'd0, 1'b0, 1'b0);
    s0_vpn = 19'h00400; s0_asid = 8'hFF; s0_odd = 1'b0; #1;
    checks++;
    if (s0_found !== 1'b1 || s0_index !== 4'd3) begin
      errors++; $display("FAIL global_hit got found=%b idx=%0d want 1/3", s0_found, s0_index);
    end
    // Write a new vpn2 into index 7 and search for it in the write cycle.
    set_write(4'd7, 19'h12AB0, 8'h11, 1'b0, 20'hABCDE, 3'd2, 1'b1, 1'b1,
              20'h0F0F0, 3'd1, 1'b0, 1'b1);
    s0_vpn = 19'h12AB0; s0_asid = 8'h11; s0_odd = 1'b0; r_index = 4'd7; #1;
    checks++;
    if (s0_found !== 1'b0) begin
      errors++; $display("FAIL collision_old got found=%b want 0", s0_found);
    end
    checks++;
    if (got_r() !== 78'd0) begin
      errors++; $display("FAIL collision_read got %h want 0", got_r());
    end
    tick();
    we = 1'b0; #1;
    checks++;
    if (got_s0() !== {1'b1, 4'd7, 20'hABCDE, 3'd2, 1'b1, 1'b1}) begin
      errors++; $display("FAIL collision_new got %h", got_s0());
    end
  endtask

  task automatic test_duplicate();
    do_write(4'd9, 19'h05555, 8'h22, 1'b0, 20'h99999, 3'd1, 1'b0, 1'b1,
             20'h99998, 3'd1, 1'b0, 1'b1);
    do_write(4'd2, 19'h05555, 8'h22, 1'b0, 20'h22222, 3'd4, 1'b1, 1'b1,
             20'h22223, 3'd5, 1'b0, 1'b1);
    s0_vpn = 19'h05555; s0_asid = 8'h22; s0_odd = 1'b0; #1;
    checks++;
    if (got_s0() !== {1'b1, 4'd2, 20'h22222, 3'd4, 1'b1, 1'b1}) begin
      errors++; $display("FAIL duplicate_low got %h idx=%0d want idx 2", got_s0(), s0_index);
    end
  endtask

  task automatic test_random_counter();
    wired = 4'd4;
    for (int k = 0; k < 40; k++) begin
      tick();
      checks++;
      if (int'(random_index) !== m_rnd || random_index < 4'd4) begin
        errors++;
        $display("FAIL random_wired4 step %0d got %0d want %0d", k, random_index, m_rnd);
      end
    end
    wired = 4'd15;
    for (int k = 0; k < 17; k++) tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (random_index !== 4'd15) begin
        errors++; $display("FAIL random_wired15 got %0d want 15", random_index);
      end
    end
    wired = 4'd0;
  endtask

  task automatic test_random_stimulus();
    logic [29:0] exp;
    for (int k = 0; k < 40; k++) begin
      do_write(4'($urandom_range(0, N - 1)), 19'h00400 + 19'($urandom_range(0, 3)),
               8'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0),
               20'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
               20'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
    end
    for (int k = 0; k < 60; k++) begin
      s0_vpn  = 19'h00400 + 19'($urandom_range(0, 4));
      s0_asid = 8'($urandom_range(0, 4));
      s0_odd  = 1'($urandom);
      r_index = 4'($urandom_range(0, N - 1));
      #1;
      exp = model_search(s0_vpn, s0_odd, s0_asid);
      checks++;
      if (got_s0() !== exp) begin
        errors++; $display("FAIL rand_search got %h want %h", got_s0(), exp);
      end
      checks++;
      if (got_r() !== model_read(int'(r_index))) begin
        errors++;
        $display("FAIL rand_read got %h want %h", got_r(), model_read(int'(r_index)));
      end
      checks++;
      if (int'(random_index) !== m_rnd) begin
        errors++; $display("FAIL rand_random got %0d want %0d", random_index, m_rnd);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_write(4'd3, 19'h00400, 8'h05, 1'b1, 20'h12345, 3'd3, 1'b1, 1'b1,
             20'h6789A, 3'd1, 1'b1, 1'b1);
    wired = 4'd4;
    tick(); tick(); tick();
    rst = 1'b1;
    set_write(4'd5, 19'h00777, 8'h01, 1'b1, 20'hFFFFF, 3'd7, 1'b1, 1'b1,
              20'hFFFFF, 3'd7, 1'b1, 1'b1);
    tick();
    rst = 1'b0; we = 1'b0;
    r_index = 4'd3; s0_vpn = 19'h00400; s0_asid = 8'h05; s0_odd = 1'b0; #1;
    checks++;
    if (random_index !== 4'd15) begin
      errors++; $display("FAIL midreset_random got %0d want 15", random_index);
    end
    checks++;
    if (got_r() !== 78'd0) begin
      errors++; $display("FAIL midreset_read3 got %h want 0", got_r());
    end
    checks++;
    if (s0_found !== 1'b0) begin
      errors++; $display("FAIL midreset_search got found=%b want 0", s0_found);
    end
    r_index = 4'd5; #1;
    checks++;
    if (got_r() !== 78'd0) begin
      errors++; $display("FAIL midreset_we_ignored got %h want 0", got_r());
    end
    wired = 4'd0;
  endtask

`ifdef TLB_DUAL_SEARCH_EN
  task automatic test_dual();
    do_write(4'd1, 19'h01111, 8'h0A, 1'b0, 20'h11111, 3'd1, 1'b0, 1'b1,
             20'h11112, 3'd1, 1'b0, 1'b1);
    do_write(4'd12, 19'h0CCCC, 8'h0B, 1'b0, 20'hCCCC0, 3'd6, 1'b1, 1'b0,
             20'hCCCC1, 3'd6, 1'b1, 1'b1);
    s0_vpn = 19'h01111; s0_asid = 8'h0A; s0_odd = 1'b0;
    s1_vpn = 19'h0CCCC; s1_asid = 8'h0B; s1_odd = 1'b1; #1;
    checks++;
    if (got_s0() !== {1'b1, 4'd1, 20'h11111, 3'd1, 1'b0, 1'b1}) begin
      errors++; $display("FAIL dual_s0 got %h", got_s0());
    end
    checks++;
    if ({s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v} !==
        {1'b1, 4'd12, 20'hCCCC1, 3'd6, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL dual_s1 got %h", {s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v});
    end
  endtask
`endif

  initial begin
    m_rnd = N - 1;
    for (int i = 0; i < N; i++) m[i] = '{default: '0};
    test_reset();
    test_basic_search();
    test_global_and_collision();
    test_duplicate();
    test_random_counter();
    test_random_stimulus();
    test_reset_mid();
`ifdef TLB_DUAL_SEARCH_EN
    test_dual();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
